vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Pixel-clock-domain VGA raster generator fed by the 25.0 MHz pixel PLL
//  (clock on clk, PLL lock status on locked). Produces HS/VS/blank timing for
//  640x480@60 and pulls RGB pixels from the upstream framebuffer reader over a
//  valid/ready stream. All outputs are registered and mutually aligned for the
//  DAC/HDMI transmitter pins.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (clocks)
//  H_SYNC    96   horizontal sync width (clocks)
//  H_BP      48   horizontal back porch (clocks); H_TOTAL = sum = 800
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines); V_TOTAL = sum = 525
//  SYNC_POL  0    sync active level (0 = active-low, per the 640x480 mode)
//  RGB_W     8    bits per colour channel
// PORTS
//  clk          in   1        pixel clock (25.0 MHz from the PLL)
//  rst          in   1        asynchronous, active-high reset
//  locked       in   1        PLL lock; asynchronous to clk, synchronised internally
//  pix_valid    in   1        upstream pixel available
//  pix_data     in   3*RGB_W  {R,G,B}
//  pix_ready    out  1        pixel consumed this cycle (pix_valid & pix_ready)
//  vga_hs       out  1        horizontal sync
//  vga_vs       out  1        vertical sync
//  vga_blank_n  out  1        1 = active video
//  vga_r/g/b    out  RGB_W    colour, 0 outside active video
//  frame_start  out  1        1-cycle pulse aligned with pixel (0,0) on the outputs
//  underflow    out  1        sticky: active pixel slot found pix_valid low
// BEHAVIOUR
//  - Reset: counters 0; vga_hs = vga_vs = ~SYNC_POL; vga_blank_n, rgb, frame_start,
//    underflow, pix_ready = 0; lock synchroniser cleared.
//  - lock_s = locked through a 2-FF synchroniser (2-cycle latency). While lock_s = 0:
//    h_cnt = v_cnt = 0, pix_ready = 0, outputs held at reset values except
//    underflow (retained).
//  - h_cnt: 0..H_TOTAL-1, wraps to 0. v_cnt increments when h_cnt wraps;
//    0..V_TOTAL-1, wraps to 0. Widths $clog2(H_TOTAL) and $clog2(V_TOTAL).
//  - active = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE). pix_ready = active & lock_s
//    (combinational from the counters); upstream must not depend on it to drive valid.
//  - Sync windows: hs when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751);
//    vs when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491);
//    outputs are at SYNC_POL inside their window.
//  - Output stage: one register stage; every output reflects the counter state of the
//    previous cycle (latency 1, all outputs aligned).
//  - Active & pix_valid: rgb <= pix_data. Active & !pix_valid: rgb <= 0, underflow <= 1,
//    no pixel consumed; raster continues without stalling. Blanking: rgb <= 0.
//  - frame_start registered from (h_cnt==0 & v_cnt==0 & lock_s).
//  - underflow clears only on rst.
//  - Lock loss mid-frame: counters restart at 0 on the first cycle lock_s is low;
//    the next frame begins cleanly (with frame_start) once lock_s returns high.
// STRUCTURE
//  - vga_timing_pkg: 640x480 default constants, derived H_TOTAL/V_TOTAL, and the
//    rgb_t typedef {R,G,B}.
//  - Sub-module lock_sync: 2-FF synchroniser, async-reset to 0.
//  - Counters, active/sync decode and the output register stage live in this module.
// TESTING
//  1. rst high, locked=1 -> all outputs at reset values. Release rst -> frame_start
//     first 1 at the 3rd clock edge after release.
//  2. Free-run, pix_valid=1 -> HS period 800 clocks, low for 96;
//     VS period 420000 clocks, low for 1600; blank_n high 640 of every 800 clocks
//     on lines 0..479.
//  3. Pixel data = incrementing counter, always valid -> 307200 pixels accepted per
//     frame; vga_r/g/b equals the beat accepted 1 cycle earlier. underflow stays 0.
//  4. Drop pix_valid for 1 cycle at (h=100, v=5) -> that pixel is output as 0 and
//     underflow goes to 1 and stays 1; the next accepted pixel is the held value.
//  5. Deassert locked at (h=300, v=200) for 10 clocks -> counters zero after the
//     2-cycle sync delay; outputs idle; the next frame_start comes after re-lock.
//  6. Assert rst mid-line -> outputs go to reset values immediately (asynchronously);
//     underflow is cleared.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the pixel type.
// Included by the raster generator and any block that needs the mode geometry.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_RGB_W    = 8;

   // Full period of one axis: visible region plus the three blanking segments.
   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

   typedef struct packed {
      logic [DEF_RGB_W-1:0] r;
      logic [DEF_RGB_W-1:0] g;
      logic [DEF_RGB_W-1:0] b;
   } rgb_t;

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser bringing the PLL lock flag into the pixel clock domain.
// Cleared by reset so the raster never starts before a fresh lock is observed.
module lock_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
               if (rst) sync_reg[gi] <= 1'b0;
               else     sync_reg[gi] <= async_in;
            end
         end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
               if (rst) sync_reg[gi] <= 1'b0;
               else     sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: h/v counters, sync/blank decode and one aligned output
// register stage; pulls one pixel per active slot from a valid/ready stream.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0,
   parameter int   RGB_W    = DEF_RGB_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               locked,
   input  logic               pix_valid,
   input  logic [3*RGB_W-1:0] pix_data,
   output logic               pix_ready,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_blank_n,
   output logic [RGB_W-1:0]   vga_r,
   output logic [RGB_W-1:0]   vga_g,
   output logic [RGB_W-1:0]   vga_b,
   output logic               frame_start,
   output logic               underflow
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic          lock_s;
   logic [HW-1:0] h_cnt_reg, h_cnt_next;
   logic [VW-1:0] v_cnt_reg, v_cnt_next;
   logic          active, hs_win, vs_win, at_origin;

   logic             hs_reg, vs_reg, blank_n_reg, frame_start_reg, underflow_reg;
   logic [RGB_W-1:0] rgb_reg [3];

   lock_sync #(.STAGES(2)) u_lock_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (locked),
      .sync_out (lock_s)
   );

   // Without lock the raster is parked at the origin so the next frame starts clean.
   always_comb begin
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      if (!lock_s) begin
         h_cnt_next = '0;
         v_cnt_next = '0;
      end else if (h_cnt_reg == H_LAST) begin
         h_cnt_next = '0;
         v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
      end else begin
         h_cnt_next = h_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
      end
   end

   always_comb begin
      active    = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
      hs_win    = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
      vs_win    = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
      at_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
   end

   assign pix_ready = active & lock_s;

   // Underflow survives a lock loss on purpose: only a full reset acknowledges it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_reg          <= ~SYNC_POL;
         vs_reg          <= ~SYNC_POL;
         blank_n_reg     <= 1'b0;
         frame_start_reg <= 1'b0;
         underflow_reg   <= 1'b0;
      end else if (!lock_s) begin
         hs_reg          <= ~SYNC_POL;
         vs_reg          <= ~SYNC_POL;
         blank_n_reg     <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         hs_reg          <= hs_win ? SYNC_POL : ~SYNC_POL;
         vs_reg          <= vs_win ? SYNC_POL : ~SYNC_POL;
         blank_n_reg     <= active;
         frame_start_reg <= at_origin;
         underflow_reg   <= underflow_reg | (active & ~pix_valid);
      end
   end

   // Channel 0 is red, taken from the most significant slice of pix_data.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rgb_reg[gi] <= '0;
            end else if (lock_s && active && pix_valid) begin
               rgb_reg[gi] <= pix_data[(2-gi)*RGB_W +: RGB_W];
            end else begin
               rgb_reg[gi] <= '0;
            end
         end
      end
   endgenerate

   assign vga_hs      = hs_reg;
   assign vga_vs      = vs_reg;
   assign vga_blank_n = blank_n_reg;
   assign vga_r       = rgb_reg[0];
   assign vga_g       = rgb_reg[1];
   assign vga_b       = rgb_reg[2];
   assign frame_start = frame_start_reg;
   assign underflow   = underflow_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run;
// every cycle is compared against a position-based model of the raster.
module tb_vga_timing_gen;

   localparam int HA = 32, HF = 4, HS = 8, HB = 6, HT = HA + HF + HS + HB;
   localparam int VA = 12, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;
   localparam int W  = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           locked = 1'b1;
   logic           pix_valid = 1'b0;
   logic [3*W-1:0] pix_data = '0;
   logic           pix_ready, vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
   logic [W-1:0]   vga_r, vga_g, vga_b;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .RGB_W(W)
   ) dut (
      .clk(clk), .rst(rst), .locked(locked),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: linear raster position since lock, and lock history seen by the raster.
   int             pos = 0;
   bit             lk1 = 0, lk2 = 0, m_uf = 0, rand_data = 0;
   logic [3*W-1:0] beat = 24'h000001;
   int             st_hs_low, st_vs_low, st_blank, st_acc, st_fs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input bit exp_uf);
      check({tag, "_hs"}, vga_hs, 1);
      check({tag, "_vs"}, vga_vs, 1);
      check({tag, "_blank_n"}, vga_blank_n, 0);
      check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_underflow"}, underflow, exp_uf);
      check({tag, "_pix_ready"}, pix_ready, 0);
   endtask

   task automatic model_reset();
      pos = 0; lk1 = 0; lk2 = 0; m_uf = 0;
   endtask

   task automatic step(input bit v_in, input bit lk_in);
      int             h, v;
      bit             act, e_hs, e_vs, e_bl, e_fs;
      logic [3*W-1:0] e_rgb;
      @(negedge clk);
      pix_valid = v_in;
      locked    = lk_in;
      pix_data  = beat;
      h   = pos % HT;
      v   = pos / HT;
      act = lk2 && (h < HA) && (v < VA);
      check("pix_ready", pix_ready, act);
      @(posedge clk);
      #1;
      if (lk2) begin
         e_hs  = !(h >= HA + HF && h < HA + HF + HS);
         e_vs  = !(v >= VA + VF && v < VA + VF + VS);
         e_bl  = act;
         e_rgb = (act && v_in) ? beat : '0;
         e_fs  = (pos == 0);
         if (act && !v_in) m_uf = 1;
         pos = (pos + 1) % FR;
      end else begin
         e_hs = 1; e_vs = 1; e_bl = 0; e_rgb = '0; e_fs = 0;
         pos = 0;
      end
      if (act && v_in) begin
         st_acc++;
         beat = rand_data ? 24'($urandom) : beat + 1'b1;
      end
      lk2 = lk1;
      lk1 = lk_in;
      check("hs", vga_hs, e_hs);
      check("vs", vga_vs, e_vs);
      check("blank_n", vga_blank_n, e_bl);
      check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
      check("frame_start", frame_start, e_fs);
      check("underflow", underflow, m_uf);
      st_hs_low += !vga_hs;
      st_vs_low += !vga_vs;
      st_blank  += vga_blank_n;
      st_fs     += frame_start;
   endtask

   task automatic clear_stats();
      st_hs_low = 0; st_vs_low = 0; st_blank = 0; st_acc = 0; st_fs = 0;
   endtask

   initial begin
      int first_fs, fs_delay, target;

      // Reset held with lock present: everything idle.
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset", 0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      first_fs = 0;
      for (int k = 1; k <= 5; k++) begin
         step(1, 1);
         if (frame_start && first_fs == 0) first_fs = k;
      end
      check("first_fs_edge", first_fs, 3);

      // Full frame of always-valid incrementing pixels.
      clear_stats();
      for (int k = 0; k < FR; k++) step(1, 1);
      check("frame_hs_low", st_hs_low, VT * HS);
      check("frame_vs_low", st_vs_low, VS * HT);
      check("frame_blank_hi", st_blank, HA * VA);
      check("frame_accepted", st_acc, HA * VA);
      check("frame_fs_count", st_fs, 1);
      check("no_underflow", underflow, 0);

      // Single missing pixel at (h=10, v=3).
      target = 3 * HT + 10;
      for (int k = 0; k < FR; k++) step(pos != target, 1);
      check("underflow_set", underflow, 1);

      // Random valid gaps and random pixel data.
      rand_data = 1;
      clear_stats();
      for (int k = 0; k < FR; k++) step($urandom_range(0, 7) != 0, 1);
      check("rand_fs_count", st_fs, 1);

      // Lock lost at (h=30, v=8) for 10 clocks.
      target = 8 * HT + 30;
      for (int k = 0; k < FR && pos != target; k++) step(1, 1);
      check("lock_target_reached", pos, target);
      clear_stats();
      for (int k = 0; k < 10; k++) step(1, 0);
      check("lock_low_no_fs", st_fs, 0);
      fs_delay = 0;
      for (int k = 1; k <= 10; k++) begin
         step(1, 1);
         if (frame_start && fs_delay == 0) fs_delay = k;
      end
      check("relock_fs_edge", fs_delay, 3);
      check("underflow_kept", underflow, 1);
      for (int k = 0; k < HT * 3 + 7; k++) step(1, 1);

      // Asynchronous reset in the middle of a line.
      #2;
      rst = 1'b1;
      #1;
      check_idle("async_rst", 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      first_fs = 0;
      for (int k = 1; k <= 5; k++) begin
         step(1, 1);
         if (frame_start && first_fs == 0) first_fs = k;
      end
      check("rerst_fs_edge", first_fs, 3);
      for (int k = 0; k < HT * 2; k++) step(1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
